vec_decode_issue: RTL and testbench

- Front stage of the vector unit. Accepts raw 32-bit RVV OP-V instructions over a valid/ready handshake and decodes them into a registered micro-op for the vector execute stage.
- Keeps a 32-entry vector-register busy scoreboard and stalls issue on RAW/WAW hazards until execute reports writeback.
- Sits directly upstream of the vector ALU/register-file datapath inside top.

---
 rtl/vec_pkg.sv | 42 ++++
 rtl/vec_scoreboard.sv | 42 ++++
 rtl/vec_decode_issue.sv | 156 +++++++++++++++
 tb/tb_vec_decode_issue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared OP-V encodings and micro-op types for the vector decode and execute stages.
package vec_pkg;

   localparam logic [6:0] OPV_OPCODE  = 7'b1010111;

   localparam logic [2:0] FUNCT3_OPIVV = 3'b000;
   localparam logic [2:0] FUNCT3_OPIVX = 3'b100;
   localparam logic [2:0] FUNCT3_OPIVI = 3'b011;

   localparam logic [5:0] FUNCT6_VADD = 6'b000000;
   localparam logic [5:0] FUNCT6_VSUB = 6'b000010;
   localparam logic [5:0] FUNCT6_VAND = 6'b001001;
   localparam logic [5:0] FUNCT6_VOR  = 6'b001010;
   localparam logic [5:0] FUNCT6_VXOR = 6'b001011;

   typedef enum logic [2:0] {
      UOP_NOP = 3'd0,
      UOP_ADD = 3'd1,
      UOP_SUB = 3'd2,
      UOP_AND = 3'd3,
      UOP_OR  = 3'd4,
      UOP_XOR = 3'd5
   } uop_op_e;

   typedef enum logic [1:0] {
      SRC_VV = 2'd0,
      SRC_VX = 2'd1,
      SRC_VI = 2'd2
   } uop_src_e;

   // Immediate is kept outside the struct so its width can follow XLEN.
   typedef struct packed {
      uop_op_e    op;
      uop_src_e   src;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic       vm;
      logic       illegal;
   } uop_t;

endpackage

// File: rtl/vec_scoreboard.sv
// Vector-register busy bits: one set port, one clear port, three combinational read ports.
module vec_scoreboard #(
   parameter int NVREG = 32,
   parameter int IDX_W = $clog2(NVREG)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             set_en,
   input  logic [IDX_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] rd_idx_a,
   input  logic [IDX_W-1:0] rd_idx_b,
   input  logic [IDX_W-1:0] rd_idx_c,
   output logic             rd_busy_a,
   output logic             rd_busy_b,
   output logic             rd_busy_c,
   output logic [NVREG-1:0] busy
);

   logic [NVREG-1:0] busy_q;
   logic [NVREG-1:0] set_mask;
   logic [NVREG-1:0] clr_mask;

   assign set_mask = set_en ? (NVREG'(1) << set_idx) : '0;
   assign clr_mask = clr_en ? (NVREG'(1) << clr_idx) : '0;

   // Set is applied after clear so a same-cycle set on the same register wins.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~clr_mask) | set_mask;
      end
   end

   assign rd_busy_a = busy_q[rd_idx_a];
   assign rd_busy_b = busy_q[rd_idx_b];
   assign rd_busy_c = busy_q[rd_idx_c];
   assign busy      = busy_q;

endmodule

// File: rtl/vec_decode_issue.sv
// Vector front stage: decodes OP-V instructions into a registered micro-op and
// holds issue on RAW/WAW hazards against the busy scoreboard.
module vec_decode_issue
   import vec_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NVREG = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      vector_instruction,
   output logic             uop_valid,
   input  logic             uop_ready,
   output logic [2:0]       uop_op,
   output logic [1:0]       uop_src,
   output logic [4:0]       uop_vd,
   output logic [4:0]       uop_vs1,
   output logic [4:0]       uop_vs2,
   output logic             uop_vm,
   output logic [XLEN-1:0]  uop_imm,
   output logic             uop_illegal,
   input  logic             wb_valid,
   input  logic [4:0]       wb_vd,
   output logic [NVREG-1:0] busy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [6:0] f_opcode;
   logic [4:0] f_vd;
   logic [2:0] f_funct3;
   logic [4:0] f_vs1;
   logic [4:0] f_vs2;
   logic       f_vm;
   logic [5:0] f_funct6;

   assign f_opcode = vector_instruction[6:0];
   assign f_vd     = vector_instruction[11:7];
   assign f_funct3 = vector_instruction[14:12];
   assign f_vs1    = vector_instruction[19:15];
   assign f_vs2    = vector_instruction[24:20];
   assign f_vm     = vector_instruction[25];
   assign f_funct6 = vector_instruction[31:26];

   uop_op_e         d_op;
   uop_src_e        d_src;
   logic            op_ok;
   logic            src_ok;
   logic            legal;
   logic [XLEN-1:0] d_imm;

   always_comb begin
      d_op  = UOP_NOP;
      op_ok = 1'b1;
      case (f_funct6)
         FUNCT6_VADD: d_op = UOP_ADD;
         FUNCT6_VSUB: d_op = UOP_SUB;
         FUNCT6_VAND: d_op = UOP_AND;
         FUNCT6_VOR:  d_op = UOP_OR;
         FUNCT6_VXOR: d_op = UOP_XOR;
         default:     op_ok = 1'b0;
      endcase
   end

   // Unknown funct3 still decodes as VV so the illegal micro-op carries sane fields.
   always_comb begin
      d_src  = SRC_VV;
      src_ok = 1'b1;
      case (f_funct3)
         FUNCT3_OPIVV: d_src = SRC_VV;
         FUNCT3_OPIVX: d_src = SRC_VX;
         FUNCT3_OPIVI: d_src = SRC_VI;
         default:      src_ok = 1'b0;
      endcase
   end

   assign legal = (f_opcode == OPV_OPCODE) && op_ok && src_ok &&
                  !((d_op == UOP_SUB) && (d_src == SRC_VI));

   assign d_imm = (d_src == SRC_VI) ? {{(XLEN-5){f_vs1[4]}}, f_vs1} : '0;

   logic busy_vd;
   logic busy_vs1;
   logic busy_vs2;
   logic hazard;
   logic accept;

   vec_scoreboard #(
      .NVREG (NVREG),
      .IDX_W (5)
   ) u_scoreboard (
      .clk       (clk),
      .rstn      (rstn),
      .set_en    (accept & legal),
      .set_idx   (f_vd),
      .clr_en    (wb_valid),
      .clr_idx   (wb_vd),
      .rd_idx_a  (f_vd),
      .rd_idx_b  (f_vs2),
      .rd_idx_c  (f_vs1),
      .rd_busy_a (busy_vd),
      .rd_busy_b (busy_vs2),
      .rd_busy_c (busy_vs1),
      .busy      (busy)
   );

   uop_t            uop_q;
   logic [XLEN-1:0] imm_q;
   logic            valid_q;

   assign hazard   = busy_vd | busy_vs2 | ((d_src == SRC_VV) & busy_vs1);
   assign in_ready = start & (~valid_q | uop_ready) & ~(legal & hazard);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         uop_q   <= '0;
         imm_q   <= '0;
      end else if (accept) begin
         valid_q       <= 1'b1;
         uop_q.op      <= legal ? d_op : UOP_NOP;
         uop_q.src     <= d_src;
         uop_q.vd      <= f_vd;
         uop_q.vs1     <= f_vs1;
         uop_q.vs2     <= f_vs2;
         uop_q.vm      <= f_vm;
         uop_q.illegal <= ~legal;
         imm_q         <= d_imm;
      end else if (uop_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (in_valid && start && !in_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign uop_valid   = valid_q;
   assign uop_op      = uop_q.op;
   assign uop_src     = uop_q.src;
   assign uop_vd      = uop_q.vd;
   assign uop_vs1     = uop_q.vs1;
   assign uop_vs2     = uop_q.vs2;
   assign uop_vm      = uop_q.vm;
   assign uop_illegal = uop_q.illegal;
   assign uop_imm     = imm_q;

endmodule

// File: tb/tb_vec_decode_issue.sv
// Self-checking bench for vec_decode_issue: directed scenarios plus randomized
// traffic compared every cycle against an instruction-level reference model.
module tb_vec_decode_issue;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] vector_instruction;
   logic        uop_valid;
   logic        uop_ready;
   logic [2:0]  uop_op;
   logic [1:0]  uop_src;
   logic [4:0]  uop_vd;
   logic [4:0]  uop_vs1;
   logic [4:0]  uop_vs2;
   logic        uop_vm;
   logic [31:0] uop_imm;
   logic        uop_illegal;
   logic        wb_valid;
   logic [4:0]  wb_vd;
   logic [31:0] busy;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   vec_decode_issue #(.XLEN(32), .NVREG(32), .CNT_W(16)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .start              (start),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .vector_instruction (vector_instruction),
      .uop_valid          (uop_valid),
      .uop_ready          (uop_ready),
      .uop_op             (uop_op),
      .uop_src            (uop_src),
      .uop_vd             (uop_vd),
      .uop_vs1            (uop_vs1),
      .uop_vs2            (uop_vs2),
      .uop_vm             (uop_vm),
      .uop_imm            (uop_imm),
      .uop_illegal        (uop_illegal),
      .wb_valid           (wb_valid),
      .wb_vd              (wb_vd),
      .busy               (busy),
      .stall_cnt          (stall_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          legal;
      logic [2:0]  op;
      logic [1:0]  src;
      logic [4:0]  vd, vs1, vs2;
      logic        vm;
      logic [31:0] imm;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      int   opc, f3, f6, v;
      opc   = int'(w % 128);
      f3    = int'((w >> 12) % 8);
      f6    = int'(w >> 26);
      d.vd  = 5'((w >> 7) % 32);
      d.vs1 = 5'((w >> 15) % 32);
      d.vs2 = 5'((w >> 20) % 32);
      d.vm  = w[25];
      case (f6)
         0:       d.op = 3'd1;
         2:       d.op = 3'd2;
         9:       d.op = 3'd3;
         10:      d.op = 3'd4;
         11:      d.op = 3'd5;
         default: d.op = 3'd0;
      endcase
      d.src = (f3 == 4) ? 2'd1 : (f3 == 3) ? 2'd2 : 2'd0;
      d.legal = (opc == 87) && (d.op != 0) && (f3 == 0 || f3 == 3 || f3 == 4) &&
                !(d.op == 2 && f3 == 3);
      v = int'(d.vs1);
      if (v >= 16) v = v - 32;
      d.imm = (f3 == 3) ? 32'(v) : 32'd0;
      return d;
   endfunction

   bit          model_ok = 0;
   bit          m_valid;
   dec_t        m_uop;
   bit          m_ill;
   logic [31:0] m_busy;
   int          m_stall;

   function automatic bit exp_ready();
      dec_t d;
      bit   haz;
      d   = decode(vector_instruction);
      haz = m_busy[d.vd] || m_busy[d.vs2] || (d.src == 0 && m_busy[d.vs1]);
      return start && (!m_valid || uop_ready) && !(d.legal && haz);
   endfunction

   always @(posedge clk) begin
      dec_t d;
      bit   r;
      if (!rstn) begin
         model_ok = 1;
         m_valid  = 0;
         m_uop    = '{legal: 0, op: 0, src: 0, vd: 0, vs1: 0, vs2: 0, vm: 0, imm: 0};
         m_ill    = 0;
         m_busy   = '0;
         m_stall  = 0;
      end else if (model_ok) begin
         d = decode(vector_instruction);
         r = exp_ready();
         if (in_valid && start && !r && m_stall < 65535) m_stall++;
         if (wb_valid) m_busy[wb_vd] = 1'b0;
         if (in_valid && r) begin
            if (d.legal) m_busy[d.vd] = 1'b1;
            m_valid = 1;
            m_uop   = d;
            if (!d.legal) m_uop.op = 3'd0;
            m_ill   = !d.legal;
         end else if (uop_ready) begin
            m_valid = 0;
         end
      end
   end

   // Per-cycle comparison against the model, after the negedge stimulus settles.
   always @(negedge clk) begin
      #2;
      if (model_ok) begin
         chk("in_ready",    64'(in_ready),    64'(exp_ready()));
         chk("uop_valid",   64'(uop_valid),   64'(m_valid));
         chk("uop_op",      64'(uop_op),      64'(m_uop.op));
         chk("uop_src",     64'(uop_src),     64'(m_uop.src));
         chk("uop_vd",      64'(uop_vd),      64'(m_uop.vd));
         chk("uop_vs1",     64'(uop_vs1),     64'(m_uop.vs1));
         chk("uop_vs2",     64'(uop_vs2),     64'(m_uop.vs2));
         chk("uop_vm",      64'(uop_vm),      64'(m_uop.vm));
         chk("uop_imm",     64'(uop_imm),     64'(m_uop.imm));
         chk("uop_illegal", 64'(uop_illegal), 64'(m_ill));
         chk("busy",        64'(busy),        64'(m_busy));
         chk("stall_cnt",   64'(stall_cnt),   64'(m_stall));
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [31:0] I_VV  = 32'h02A28A57;
   localparam logic [31:0] I_RAW = 32'h03428AD7;
   localparam logic [31:0] I_VI  = 32'h024FB1D7;
   localparam logic [31:0] I_ILL = 32'h00000013;

   task automatic step(input logic iv, input logic [31:0] ins, input logic ur,
                       input logic wbv, input logic [4:0] wbd);
      @(negedge clk);
      in_valid           = iv;
      vector_instruction = ins;
      uop_ready          = ur;
      wb_valid           = wbv;
      wb_vd              = wbd;
      #3;
   endtask

   function automatic logic [63:0] snap();
      return 64'({uop_valid, uop_op, uop_src, uop_vd, uop_vs1, uop_vs2, uop_vm, uop_imm, uop_illegal});
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] f6;
      logic [2:0] f3;
      logic [6:0] opc;
      logic [5:0] f6_tab [6];
      logic [2:0] f3_tab [4];
      f6_tab = '{6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b001011, 6'b010101};
      f3_tab = '{3'b000, 3'b100, 3'b011, 3'b111};
      f6  = f6_tab[$urandom_range(0, 5)];
      f3  = f3_tab[$urandom_range(0, 3)];
      opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'b1010111;
      return {f6, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              f3, 5'($urandom_range(0, 7)), opc};
   endfunction

   logic [31:0] busy_snap;
   logic [63:0] out_snap;

   initial begin
      rstn = 1'b0; start = 1'b0; in_valid = 1'b0; vector_instruction = '0;
      uop_ready = 1'b0; wb_valid = 1'b0; wb_vd = '0;
      repeat (2) @(negedge clk);

      // reset state
      @(negedge clk);
      rstn = 1'b1; start = 1'b1; in_valid = 1'b0;
      #3;
      chk("rst_uop_valid", 64'(uop_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_stall",     64'(stall_cnt), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);

      // single VV then RAW stall on v20
      step(1, I_VV, 1, 0, 0);
      chk("vv_accept", 64'(in_ready), 64'd1);
      step(1, I_RAW, 1, 0, 0);
      chk("vv_valid", 64'(uop_valid), 64'd1);
      chk("vv_op",    64'(uop_op),    64'd1);
      chk("vv_src",   64'(uop_src),   64'd0);
      chk("vv_vd",    64'(uop_vd),    64'd20);
      chk("vv_vs1",   64'(uop_vs1),   64'd5);
      chk("vv_vs2",   64'(uop_vs2),   64'd10);
      chk("vv_vm",    64'(uop_vm),    64'd1);
      chk("vv_ill",   64'(uop_illegal), 64'd0);
      chk("vv_busy20", 64'(busy[20]), 64'd1);
      chk("raw_stall", 64'(in_ready), 64'd0);
      step(1, I_RAW, 1, 0, 0);
      chk("vv_drained", 64'(uop_valid), 64'd0);
      step(1, I_RAW, 1, 0, 0);
      chk("raw_stall_cnt2", 64'(stall_cnt), 64'd2);
      step(1, I_RAW, 1, 1, 5'd20);
      chk("raw_stall_wbcycle", 64'(in_ready), 64'd0);
      step(1, I_RAW, 1, 0, 0);
      chk("raw_go",       64'(in_ready),  64'd1);
      chk("raw_stall_cnt", 64'(stall_cnt), 64'd4);
      step(0, I_VI, 1, 0, 0);
      chk("raw_vd",     64'(uop_vd),   64'd21);
      chk("raw_busy21", 64'(busy[21]), 64'd1);
      chk("raw_busy20", 64'(busy[20]), 64'd0);

      // VI immediate
      step(1, I_VI, 1, 0, 0);
      chk("vi_accept", 64'(in_ready), 64'd1);
      step(1, I_ILL, 1, 0, 0);
      chk("vi_src", 64'(uop_src), 64'd2);
      chk("vi_vd",  64'(uop_vd),  64'd3);
      chk("vi_vs1", 64'(uop_vs1), 64'd31);
      chk("vi_vs2", 64'(uop_vs2), 64'd4);
      chk("vi_imm", 64'(uop_imm), 64'hFFFFFFFF);
      chk("ill_no_stall", 64'(in_ready), 64'd1);
      busy_snap = busy;

      // illegal
      step(0, I_ILL, 1, 0, 0);
      chk("ill_valid", 64'(uop_valid),   64'd1);
      chk("ill_flag",  64'(uop_illegal), 64'd1);
      chk("ill_op",    64'(uop_op),      64'd0);
      chk("ill_busy",  64'(busy),        64'(busy_snap));
      chk("ill_busy_bits", 64'(busy), 64'h0020_0008);

      // backpressure
      step(1, I_VV, 1, 0, 0);
      chk("bp_accept", 64'(in_ready), 64'd1);
      step(1, I_ILL, 0, 0, 0);
      out_snap = snap();
      chk("bp_held_vd", 64'(uop_vd), 64'd20);
      chk("bp_ready0",  64'(in_ready), 64'd0);
      for (int i = 0; i < 2; i++) begin
         step(1, I_ILL, 0, 0, 0);
         chk("bp_ready_hold", 64'(in_ready), 64'd0);
         chk("bp_stable",     snap(),        out_snap);
      end
      step(0, I_ILL, 1, 0, 0);
      chk("bp_release_still_valid", 64'(uop_valid), 64'd1);
      step(0, I_ILL, 1, 0, 0);
      chk("bp_drop", 64'(uop_valid), 64'd0);

      // stall counter saturation against a permanently busy v20
      for (int i = 0; i < 65540; i++) step(1, I_RAW, 1, 0, 0);
      chk("stall_sat", 64'(stall_cnt), 64'hFFFF);

      // start low blocks issue but writeback still clears
      start = 1'b0;
      step(1, I_ILL, 1, 1, 5'd20);
      chk("start_low_ready", 64'(in_ready), 64'd0);
      step(0, I_ILL, 1, 0, 0);
      chk("start_low_wb", 64'(busy[20]), 64'd0);
      start = 1'b1;

      // mid-operation reset
      step(1, I_VV, 0, 0, 0);
      @(negedge clk);
      rstn = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      #3;
      chk("midrst_valid", 64'(uop_valid), 64'd0);
      chk("midrst_busy",  64'(busy),      64'd0);
      chk("midrst_stall", 64'(stall_cnt), 64'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rstn               = ($urandom_range(0, 199) != 0);
         start              = ($urandom_range(0, 9) != 0);
         in_valid           = ($urandom_range(0, 3) != 0);
         vector_instruction = rand_instr();
         uop_ready          = ($urandom_range(0, 3) != 0);
         wb_valid           = ($urandom_range(0, 9) < 4);
         wb_vd              = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      @(negedge clk);
      rstn = 1'b1; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #3;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
